// File: rtl/ofdm_decode_ctrl_if.sv
// Link between the OFDM decode sequencer and the decoder datapath: decoder
// configuration, decoded-byte return path and upstream sample gating.
interface ofdm_decode_ctrl_if;
  logic        sample_in_strobe;
  logic        sample_accept;
  logic [7:0]  byte_in;
  logic        byte_in_strobe;
  logic        dec_reset;
  logic        dec_enable;
  logic [7:0]  dec_rate;
  logic        dec_do_descramble;
  logic [31:0] dec_num_bits;

  modport master (
    input  sample_in_strobe, byte_in, byte_in_strobe,
    output sample_accept, dec_reset, dec_enable, dec_rate, dec_do_descramble, dec_num_bits
  );

  modport slave (
    output sample_in_strobe, byte_in, byte_in_strobe,
    input  sample_accept, dec_reset, dec_enable, dec_rate, dec_do_descramble, dec_num_bits
  );
endinterface

// File: rtl/ofdm_decode_ctrl.sv
// Per-packet sequencer for the OFDM decoder: SIGNAL decode and check, DATA
// coded-bit budget via a serial divider, then PSDU byte counting to packet end.
module ofdm_decode_ctrl #(
  parameter int SIG_TIMEOUT = 1024,
  parameter int MAX_LEN     = 4095
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic               start,
  input  logic               abort,
  ofdm_decode_ctrl_if.master dec,
  output logic [3:0]         pkt_rate,
  output logic [11:0]        pkt_len,
  output logic               sig_valid,
  output logic               sig_error,
  output logic               pkt_done,
  output logic               busy
);
  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_SIG_RST  = 3'd1;
  localparam logic [2:0] S_SIG      = 3'd2;
  localparam logic [2:0] S_CHECK    = 3'd3;
  localparam logic [2:0] S_DIV      = 3'd4;
  localparam logic [2:0] S_DATA_RST = 3'd5;
  localparam logic [2:0] S_DATA     = 3'd6;

  localparam int              TW         = $clog2(SIG_TIMEOUT + 1);
  localparam logic [TW-1:0]   TIMER_LAST = TW'(SIG_TIMEOUT - 1);
  localparam logic [11:0]     LEN_MAX    = 12'(MAX_LEN);

  function automatic logic [7:0] ndbps_of(input logic [3:0] r);
    case (r)
      4'hB:    ndbps_of = 8'd24;
      4'hF:    ndbps_of = 8'd36;
      4'hA:    ndbps_of = 8'd48;
      4'hE:    ndbps_of = 8'd72;
      4'h9:    ndbps_of = 8'd96;
      4'hD:    ndbps_of = 8'd144;
      4'h8:    ndbps_of = 8'd192;
      4'hC:    ndbps_of = 8'd216;
      default: ndbps_of = 8'd0;
    endcase
  endfunction

  logic [2:0]    state;
  logic [17:0]   sig;
  logic [11:0]   byte_cnt;
  logic [16:0]   samp_cnt;
  logic [16:0]   samp_tgt;
  logic [TW-1:0] sig_timer;
  logic [7:0]    ndbps;
  logic [15:0]   div_q;
  logic [7:0]    div_rem;
  logic [4:0]    div_cnt;
  logic [7:0]    rate_q;
  logic          desc_q;
  logic [31:0]   nbits_q;

  logic [3:0]  sig_rate;
  logic [11:0] sig_len;
  logic        sig_ok;
  logic [8:0]  div_trial;
  logic [8:0]  div_diff;
  logic [15:0] nsym;
  logic [23:0] nbits_prod;
  logic [16:0] nsym_samps;

  assign sig_rate = sig[3:0];
  assign sig_len  = sig[16:5];
  assign sig_ok   = ~^sig && !sig[4] && (ndbps_of(sig_rate) != 8'd0) &&
                    (sig_len != 12'd0) && (sig_len <= LEN_MAX);

  // Remainder stays below NDBPS (<256), so bit 8 of the difference is the borrow.
  assign div_trial  = {div_rem, div_q[15]};
  assign div_diff   = div_trial - {1'b0, ndbps};
  assign nsym       = div_q + {15'd0, |div_rem};
  assign nbits_prod = {8'd0, nsym} * {16'd0, ndbps};
  assign nsym_samps = {1'b0, nsym} * 17'd48;

  assign busy                  = (state != S_IDLE);
  assign dec.dec_reset         = (state == S_IDLE) || (state == S_SIG_RST) || (state == S_DATA_RST);
  assign dec.dec_enable        = busy;
  assign dec.dec_rate          = rate_q;
  assign dec.dec_do_descramble = desc_q;
  assign dec.dec_num_bits      = nbits_q;
  assign dec.sample_accept     = ((state == S_SIG)  && (samp_cnt < 17'd48)) ||
                                 ((state == S_DATA) && (samp_cnt < samp_tgt));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      sig       <= '0;
      byte_cnt  <= '0;
      samp_cnt  <= '0;
      samp_tgt  <= '0;
      sig_timer <= '0;
      ndbps     <= '0;
      div_q     <= '0;
      div_rem   <= '0;
      div_cnt   <= '0;
      rate_q    <= 8'h0B;
      desc_q    <= 1'b0;
      nbits_q   <= 32'd48;
      pkt_rate  <= '0;
      pkt_len   <= '0;
      sig_valid <= 1'b0;
      sig_error <= 1'b0;
      pkt_done  <= 1'b0;
    end else begin
      sig_error <= 1'b0;
      pkt_done  <= 1'b0;
      if (abort) begin
        state     <= S_IDLE;
        sig_valid <= 1'b0;
      end else if (enable) begin
        case (state)
          S_IDLE: if (start) begin
            state   <= S_SIG_RST;
            rate_q  <= 8'h0B;
            desc_q  <= 1'b0;
            nbits_q <= 32'd48;
          end
          S_SIG_RST: begin
            samp_cnt  <= '0;
            byte_cnt  <= '0;
            sig_timer <= '0;
            sig       <= '0;
            state     <= S_SIG;
          end
          S_SIG: begin
            sig_timer <= sig_timer + TW'(1);
            if (dec.sample_in_strobe && dec.sample_accept) samp_cnt <= samp_cnt + 17'd1;
            if (dec.byte_in_strobe) begin
              byte_cnt <= byte_cnt + 12'd1;
              case (byte_cnt[1:0])
                2'd0:    sig[7:0]   <= dec.byte_in;
                2'd1:    sig[15:8]  <= dec.byte_in;
                default: sig[17:16] <= dec.byte_in[1:0];
              endcase
            end
            // A completing third byte wins over a timeout landing on the same cycle.
            if (dec.byte_in_strobe && byte_cnt == 12'd2) begin
              state <= S_CHECK;
            end else if (sig_timer == TIMER_LAST) begin
              sig_error <= 1'b1;
              state     <= S_IDLE;
            end
          end
          S_CHECK: begin
            if (sig_ok) begin
              pkt_rate  <= sig_rate;
              pkt_len   <= sig_len;
              sig_valid <= 1'b1;
              ndbps     <= ndbps_of(sig_rate);
              div_q     <= 16'd22 + {1'b0, sig_len, 3'b000};
              div_rem   <= '0;
              div_cnt   <= '0;
              state     <= S_DIV;
            end else begin
              sig_error <= 1'b1;
              state     <= S_IDLE;
            end
          end
          S_DIV: begin
            if (div_cnt == 5'd16) begin
              nbits_q  <= {7'd0, nbits_prod, 1'b0};
              samp_tgt <= nsym_samps;
              rate_q   <= {4'b0, pkt_rate};
              desc_q   <= 1'b1;
              state    <= S_DATA_RST;
            end else begin
              div_cnt <= div_cnt + 5'd1;
              if (!div_diff[8]) begin
                div_rem <= div_diff[7:0];
                div_q   <= {div_q[14:0], 1'b1};
              end else begin
                div_rem <= div_trial[7:0];
                div_q   <= {div_q[14:0], 1'b0};
              end
            end
          end
          S_DATA_RST: begin
            samp_cnt <= '0;
            byte_cnt <= '0;
            state    <= S_DATA;
          end
          S_DATA: begin
            if (dec.sample_in_strobe && dec.sample_accept) samp_cnt <= samp_cnt + 17'd1;
            if (dec.byte_in_strobe) begin
              byte_cnt <= byte_cnt + 12'd1;
              if (byte_cnt + 12'd1 == pkt_len) begin
                pkt_done  <= 1'b1;
                sig_valid <= 1'b0;
                state     <= S_IDLE;
              end
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end
endmodule
